ram_write_arbiter: RTL

RAM_WRITE_ARBITER -- requirements
Module: ram_write_arbiter

---
 rtl/ram_write_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ram_write_arbiter.sv
// Two-requester round-robin write arbiter for the shared data RAM.
// Bounded bursts per grant; a single registered write port toward the RAM.
//
// state  | meaning
// IDLE   | no owner, waiting for a valid request
// GRANT0 | requester 0 (ALU writeback) owns the RAM write port
// GRANT1 | requester 1 (host loader) owns the RAM write port
module ram_write_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iReq0Valid,
    input  logic [ADDR_WIDTH-1:0] iReq0Addr,
    input  logic [DATA_WIDTH-1:0] iReq0Data,
    output logic                  oReq0Ready,
    input  logic                  iReq1Valid,
    input  logic [ADDR_WIDTH-1:0] iReq1Addr,
    input  logic [DATA_WIDTH-1:0] iReq1Data,
    output logic                  oReq1Ready,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [DATA_WIDTH-1:0] oDataIn,
    output logic [1:0]            oGrant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arbState_t;

    localparam logic [3:0] BurstMax = 4'(MAX_BURST);

    arbState_t  state;
    arbState_t  nextState;
    logic       rLast;
    logic [3:0] burstCount;
    logic       xfer0;
    logic       xfer1;
    logic       burstDone;

    assign xfer0 = iReq0Valid && (state == GRANT0);
    assign xfer1 = iReq1Valid && (state == GRANT1);

    // The transfer at this edge counts toward the burst, so the owner
    // yields right after its MAX_BURST-th write rather than one later.
    assign burstDone = ({1'b0, burstCount} + 5'd1) >= {1'b0, BurstMax};

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (iReq0Valid && iReq1Valid) begin
                    nextState = rLast ? GRANT0 : GRANT1;
                end else if (iReq0Valid) begin
                    nextState = GRANT0;
                end else if (iReq1Valid) begin
                    nextState = GRANT1;
                end
            end
            GRANT0: begin
                if (iReq0Valid) begin
                    if (burstDone && iReq1Valid) begin
                        nextState = GRANT1;
                    end
                end else if (iReq1Valid) begin
                    nextState = GRANT1;
                end else begin
                    nextState = IDLE;
                end
            end
            GRANT1: begin
                if (iReq1Valid) begin
                    if (burstDone && iReq0Valid) begin
                        nextState = GRANT0;
                    end
                end else if (iReq0Valid) begin
                    nextState = GRANT0;
                end else begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            rLast      <= 1'b1;
            burstCount <= 4'd0;
        end else begin
            state <= nextState;
            if (nextState == GRANT0) begin
                rLast <= 1'b0;
            end else if (nextState == GRANT1) begin
                rLast <= 1'b1;
            end
            if (nextState != state) begin
                burstCount <= 4'd0;
            end else if ((xfer0 || xfer1) && (burstCount < BurstMax)) begin
                burstCount <= burstCount + 4'd1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oWriteEnable  <= 1'b0;
            oWriteAddress <= '0;
            oDataIn       <= '0;
        end else begin
            oWriteEnable <= xfer0 || xfer1;
            if (xfer0) begin
                oWriteAddress <= iReq0Addr;
                oDataIn       <= iReq0Data;
            end else if (xfer1) begin
                oWriteAddress <= iReq1Addr;
                oDataIn       <= iReq1Data;
            end
        end
    end

    assign oReq0Ready = (state == GRANT0);
    assign oReq1Ready = (state == GRANT1);
    assign oGrant     = {state == GRANT1, state == GRANT0};

endmodule
